countup_ctrl: RTL
=================

Name: countup_ctrl

Overview:
- Run/pause/clear sequencer for the 6-digit countup BCD datapath on the DE10-Lite (50 MHz MAX10 clock).
- Debounces the two pushbuttons and generates a rate-selectable increment strobe from a prescaler.
- Drives one-cycle CNT_INC / CNT_CLR pulses into the counter datapath, which in turn drives HEX0..HEX5.
- Reports controller state on LEDs.

Parameters:
- DIV_BASE, 5000000, prescaler divisor for rate 0 (10 Hz at 50 MHz); must be >= 100.
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples required to accept a key level change (10 ms).

Ports:
- MAX10_CLK1_50  in  1  system clock, 50 MHz
- RST  in  1  reset, synchronous, active-high
- KEY_START  in  1  raw pushbutton, active-low; toggles run/pause
- KEY_CLEAR  in  1  raw pushbutton, active-low; clears the count
- SW  in  10  [1:0] rate select, [8] wrap enable, [9] hold; others reserved
- CNT_MAX  in  1  datapath value is 999999
- CNT_INC  out  1  one-cycle increment strobe to the datapath
- CNT_CLR  out  1  one-cycle clear strobe to the datapath
- STATE_LED  out  4  one-hot state: [0] IDLE, [1] RUN, [2] PAUSE, [3] DONE

Behaviour:
- Reset values:
  - State IDLE; STATE_LED = 4'b0001.
  - CNT_INC = 0, CNT_CLR = 0.
  - Prescaler = 0.
  - Debounced key levels = 1 (released); sync flops = 1.
  - RST mid-operation forces all of these on the next edge, with no pulses emitted.
- Key path, per key:
  - 2-flop synchronizer, then a stability counter.
  - The debounced level changes after DEBOUNCE_CYCLES consecutive samples that differ from it; any mismatch restarts the count.
  - A press event is a one-cycle pulse registered on the cycle after the debounced level falls 1->0. Releases generate nothing.
  - Holding a key produces exactly one event.
- Rate divisor (div):
  - SW[1:0]=0 -> DIV_BASE; 1 -> DIV_BASE/10; 2 -> DIV_BASE/100; 3 -> 1 (tick every cycle).
- Prescaler:
  - Advances only in RUN with SW[9]=0; it holds its value during hold or PAUSE.
  - When prescaler == div-1 it produces a tick and returns to 0.
  - Cleared to 0 on IDLE->RUN, on a clear event, and on any change of SW[1:0].
- FSM:
  - IDLE: start event -> RUN.
  - RUN: start event -> PAUSE.
  - RUN, tick with CNT_MAX=1 and SW[8]=0: -> DONE; no CNT_INC.
  - RUN, tick otherwise: CNT_INC=1 for that cycle and stay in RUN. With wrap, the datapath rolls 999999->0.
  - PAUSE: start event -> RUN; the prescaler resumes from its held value.
  - DONE: start events are ignored.
  - Any state, clear event: CNT_CLR=1 for one cycle, next state IDLE, prescaler reset.
- Simultaneous events:
  - Clear has priority over start and over tick; no CNT_INC in the clear cycle.
  - A start event in the same cycle as a RUN tick gives PAUSE, and the tick's CNT_INC is still issued.
- Outputs are registered. CNT_INC rises the cycle after the prescaler reaches div-1.
- CNT_INC and CNT_CLR are never high in the same cycle.

Optional Feature:
- Macro: COUNTUP_CTRL_DOWN_EN.
- When defined:
  - Adds input CNT_MIN (1, datapath value is 0) and output CNT_DIR (1, 1=down).
  - CNT_DIR latches SW[7] on every entry to RUN and is stable while running; reset value is 0.
  - When CNT_DIR=1, the terminal/DONE check uses CNT_MIN instead of CNT_MAX.
- When undefined: CNT_MIN and CNT_DIR are absent, SW[7] is ignored, and the block is up-count only.

Decomposition:
- Package countup_pkg holds:
  - the state enum (IDLE/RUN/PAUSE/DONE);
  - rate-select codes;
  - the one-hot STATE_LED encodings;
  - the SW bit-index constants (RATE_LO/HI, WRAP, HOLD, DIR).
- Sub-module key_debounce (synchronizer + stability counter + press-pulse), parameterized by DEBOUNCE_CYCLES and instantiated once per key.

Test Plan (sim parameters: DEBOUNCE_CYCLES=4, DIV_BASE=1000):
- Reset, SW=3, KEY_START low for 20 cycles then high -> exactly one start event; STATE_LED=0010; CNT_INC high every cycle thereafter.
- KEY_START glitch low for 3 cycles -> no event; STATE_LED remains 0001.
- RUN with SW[1:0]=0 -> CNT_INC pulses exactly 1000 cycles apart; SW[9]=1 for 500 cycles -> gap becomes 1500.
- RUN, SW=3, CNT_MAX=1, SW[8]=0 -> no CNT_INC, STATE_LED=1000; further start presses are ignored. Same with SW[8]=1 -> CNT_INC continues, state stays RUN.
- Clear and start events in the same cycle while in RUN -> CNT_CLR one cycle, CNT_INC=0, STATE_LED=0001.
- RST asserted for 1 cycle mid-RUN -> next cycle STATE_LED=0001, CNT_INC=0, CNT_CLR=0, prescaler restarts from 0 on the next start.

Source files
------------

// File: rtl/countup_pkg.sv
// Shared types and constants for the countup run/pause/clear controller.
package countup_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] RATE_SEL_BASE   = 2'd0;
  localparam logic [1:0] RATE_SEL_DIV10  = 2'd1;
  localparam logic [1:0] RATE_SEL_DIV100 = 2'd2;
  localparam logic [1:0] RATE_SEL_FAST   = 2'd3;

  localparam logic [3:0] LED_IDLE  = 4'b0001;
  localparam logic [3:0] LED_RUN   = 4'b0010;
  localparam logic [3:0] LED_PAUSE = 4'b0100;
  localparam logic [3:0] LED_DONE  = 4'b1000;

  localparam int RATE_LO = 0;
  localparam int RATE_HI = 1;
  localparam int DIR     = 7;
  localparam int WRAP    = 8;
  localparam int HOLD    = 9;

  function automatic logic [3:0] state_led(input state_e s);
    case (s)
      ST_IDLE:  return LED_IDLE;
      ST_RUN:   return LED_RUN;
      ST_PAUSE: return LED_PAUSE;
      ST_DONE:  return LED_DONE;
      default:  return LED_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/countup_ctrl_key_debounce.sv
// Active-low pushbutton conditioner: 2-flop synchronizer, stability counter,
// and a one-cycle press pulse on each debounced 1->0 transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_q;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  logic          w_differs;
  logic          w_accept;

  assign w_differs = (r_sync2 != r_level);
  assign w_accept  = w_differs && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_level   <= 1'b1;
      r_level_q <= 1'b1;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_key_n;
      r_sync2   <= r_sync1;
      r_level_q <= r_level;
      // Any sample that agrees with the accepted level restarts the run.
      if (!w_differs || w_accept) r_cnt <= '0;
      else                        r_cnt <= r_cnt + 1'b1;
      if (w_accept) r_level <= r_sync2;
      r_press <= r_level_q & ~r_level;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/countup_ctrl.sv
// Run/pause/clear sequencer for the 6-digit countup datapath.
// Optional down-count support is built when COUNTUP_CTRL_DOWN_EN is defined.
module countup_ctrl
  import countup_pkg::*;
#(
  parameter int DIV_BASE        = 5000000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       MAX10_CLK1_50,
  input  logic       RST,
  input  logic       KEY_START,
  input  logic       KEY_CLEAR,
  input  logic [9:0] SW,
  input  logic       CNT_MAX,
`ifdef COUNTUP_CTRL_DOWN_EN
  input  logic       CNT_MIN,
  output logic       CNT_DIR,
`endif
  output logic       CNT_INC,
  output logic       CNT_CLR,
  output logic [3:0] STATE_LED
);

  localparam int PW = $clog2(DIV_BASE);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_div_m1;
  logic [1:0]    r_rate_q;
  logic          r_inc;
  logic          r_clr;
  logic [3:0]    r_led;
  logic          w_inc_nxt;
  logic          w_clr_nxt;
  logic          w_start;
  logic          w_clear;
  logic          w_advance;
  logic          w_tick;
  logic          w_term;
  logic          w_rate_chg;
  logic          w_presc_clr;
  logic          w_unused;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_start (
    .i_clk   (MAX10_CLK1_50),
    .i_rst   (RST),
    .i_key_n (KEY_START),
    .o_press (w_start)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clear (
    .i_clk   (MAX10_CLK1_50),
    .i_rst   (RST),
    .i_key_n (KEY_CLEAR),
    .o_press (w_clear)
  );

  always_comb begin
    w_div_m1 = '0;
    case (SW[RATE_HI:RATE_LO])
      RATE_SEL_BASE:   w_div_m1 = PW'(DIV_BASE - 1);
      RATE_SEL_DIV10:  w_div_m1 = PW'(DIV_BASE / 10 - 1);
      RATE_SEL_DIV100: w_div_m1 = PW'(DIV_BASE / 100 - 1);
      default:         w_div_m1 = '0;
    endcase
  end

  assign w_advance  = (r_state == ST_RUN) && !SW[HOLD];
  assign w_tick     = w_advance && (r_presc == w_div_m1);
  assign w_rate_chg = (SW[RATE_HI:RATE_LO] != r_rate_q);

`ifdef COUNTUP_CTRL_DOWN_EN
  logic r_dir;

  always_ff @(posedge MAX10_CLK1_50) begin
    if (RST)                                                r_dir <= 1'b0;
    else if (w_state_nxt == ST_RUN && r_state != ST_RUN)    r_dir <= SW[DIR];
  end

  assign w_term  = r_dir ? CNT_MIN : CNT_MAX;
  assign CNT_DIR = r_dir;
`else
  assign w_term = CNT_MAX;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_inc_nxt   = 1'b0;
    w_clr_nxt   = 1'b0;
    if (w_clear) begin
      w_clr_nxt   = 1'b1;
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_start) w_state_nxt = ST_RUN;
        ST_RUN: begin
          // Terminal count without wrap stops the run even if start is pressed.
          if (w_tick && w_term && !SW[WRAP]) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_inc_nxt = w_tick;
            if (w_start) w_state_nxt = ST_PAUSE;
          end
        end
        ST_PAUSE: if (w_start) w_state_nxt = ST_RUN;
        ST_DONE:  w_state_nxt = ST_DONE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_presc_clr = w_clear || w_rate_chg ||
                       (r_state == ST_IDLE && w_state_nxt == ST_RUN);

  always_ff @(posedge MAX10_CLK1_50) begin
    r_rate_q <= SW[RATE_HI:RATE_LO];
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_inc   <= 1'b0;
      r_clr   <= 1'b0;
      r_led   <= LED_IDLE;
      r_presc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_inc   <= w_inc_nxt;
      r_clr   <= w_clr_nxt;
      r_led   <= state_led(w_state_nxt);
      if (w_presc_clr || w_tick) r_presc <= '0;
      else if (w_advance)        r_presc <= r_presc + 1'b1;
    end
  end

  assign CNT_INC   = r_inc;
  assign CNT_CLR   = r_clr;
  assign STATE_LED = r_led;

  assign w_unused = ^SW[7:2];

endmodule
